// File: rtl/mult_hilo_unit_if.sv
// ---------------------------------------------------------------------------
// mult_hilo_unit_if
//   Groups the decode-side request signals and the unit's status/read-back
//   signals of the HI/LO multiply unit into one bundle.
//
//   master : pipeline/decode side (drives requests, reads status and data)
//   slave  : the multiply unit itself
//
//   mult_we      start request (MULT/MULTU in EX)
//   is_signed    1 = MULT, 0 = MULTU
//   src_a/src_b  multiplicand / multiplier
//   mf_req       MFHI/MFLO in EX needs HI/LO this cycle
//   mf_hilo_sel  0 = read LO, 1 = read HI
//   hilo_rd      selected HI or LO value
//   busy, done   iteration in progress / one-cycle completion pulse
//   stall        pipeline must hold while the unit is busy
// ---------------------------------------------------------------------------
interface mult_hilo_unit_if #(
    parameter int WIDTH = 32
);
    logic             mult_we;
    logic             is_signed;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             mf_req;
    logic             mf_hilo_sel;
    logic [WIDTH-1:0] hilo_rd;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output mult_we, is_signed, src_a, src_b, mf_req, mf_hilo_sel,
        input  hilo_rd, busy, done, stall
    );

    modport slave (
        input  mult_we, is_signed, src_a, src_b, mf_req, mf_hilo_sel,
        output hilo_rd, busy, done, stall
    );
endinterface

// File: rtl/mult_hilo_unit.sv
// ---------------------------------------------------------------------------
// mult_hilo_unit
//   Iterative shift-add multiplier that owns the HI/LO register pair.
//   A start request in IDLE latches the operands and runs WIDTH shift-add
//   steps; the full 2*WIDTH product lands in {HI,LO} on the last step.
//   While busy, MFHI/MFLO reads and further MULT requests stall the pipeline.
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   mult_hilo_unit_if.slave (requests, operands, status, read data)
//
//   Configuration macro:
//     MULT_SIGNED_EN  when defined, is_signed=1 multiplies two's complement
//                     operands; when undefined every operation is unsigned.
// ---------------------------------------------------------------------------
module mult_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    mult_hilo_unit_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               negProd_q, negProd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               negA, negB;
    logic [WIDTH-1:0]   magA, magB;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] accStep;
    logic [2*WIDTH-1:0] product;
    logic               unusedAccLsb;

    // Operand signs only matter in signed mode; the unsigned-only build
    // treats every operand as a plain magnitude.
`ifdef MULT_SIGNED_EN
    assign negA = bus.is_signed & bus.src_a[WIDTH-1];
    assign negB = bus.is_signed & bus.src_b[WIDTH-1];
`else
    logic unusedIsSigned;
    assign unusedIsSigned = bus.is_signed;
    assign negA = 1'b0;
    assign negB = 1'b0;
`endif

    assign magA = negA ? -bus.src_a : bus.src_a;
    assign magB = negB ? -bus.src_b : bus.src_b;

    // One shift-add step: add the multiplicand into the upper half with a
    // carry bit, then shift {carry, acc} right. The bit falling off the
    // bottom is always a zero from the cleared start value.
    assign addend       = mplier_q[0] ? mcand_q : '0;
    assign sum          = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    assign accStep      = {sum, acc_q[WIDTH-1:1]};
    assign unusedAccLsb = acc_q[0];
    assign product      = negProd_q ? -accStep : accStep;

    // State and datapath registers; reset discards any in-flight product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            negProd_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            negProd_q <= negProd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic. Requests arriving in RUN are simply ignored here;
    // the stall output makes the pipeline retry them once IDLE again.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        negProd_d = negProd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mult_we) begin
                    state_d   = RUN;
                    count_d   = '0;
                    acc_d     = '0;
                    mcand_d   = magA;
                    mplier_d  = magB;
                    negProd_d = negA ^ negB;
                    busy_d    = 1'b1;
                end
            end
            RUN: begin
                acc_d    = accStep;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = IDLE;
                    count_d = '0;
                    hi_d    = product[2*WIDTH-1:WIDTH];
                    lo_d    = product[WIDTH-1:0];
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.hilo_rd = bus.mf_hilo_sel ? hi_q : lo_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.stall   = busy_q & (bus.mf_req | bus.mult_we);
endmodule

// File: tb/tb_mult_hilo_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_hilo_unit
//   Self-checking bench for mult_hilo_unit: directed scenarios followed by
//   random operands compared against a plain arithmetic product model.
// ---------------------------------------------------------------------------
module tb_mult_hilo_unit;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    mult_hilo_unit_if #(.WIDTH(WIDTH)) bus ();

    mult_hilo_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference product from ordinary 64-bit arithmetic on sign/zero-extended operands.
    function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b,
                                               input logic s);
        logic [63:0] ea, eb;
        logic        useSigned;
`ifdef MULT_SIGNED_EN
        useSigned = s;
`else
        useSigned = 1'b0 & s;
`endif
        ea = useSigned ? {{32{a[31]}}, a} : {32'b0, a};
        eb = useSigned ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic readHiLo(output logic [31:0] hi, output logic [31:0] lo);
        bus.mf_hilo_sel = 1'b0;
        #1 lo = bus.hilo_rd;
        bus.mf_hilo_sel = 1'b1;
        #1 hi = bus.hilo_rd;
        bus.mf_hilo_sel = 1'b0;
    endtask

    // Present operands with mult_we for exactly one start edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.src_a     = a;
        bus.src_b     = b;
        bus.is_signed = s;
        bus.mult_we   = 1'b1;
        tick();
        bus.mult_we   = 1'b0;
    endtask

    // Full multiply: busy for WIDTH cycles, then done pulse and result.
    task automatic runMult(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic mfCheck,
                           output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] exp;
        int          errs;
        exp = refProduct(a, b, s);
        errs = 0;
        bus.mf_req      = mfCheck;
        bus.mf_hilo_sel = 1'b0;
        applyStimulus(a, b, s);
        for (int i = 0; i < WIDTH; i++) begin
            if (i > 0) tick();
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) errs++;
            if (mfCheck && bus.stall !== 1'b1) errs++;
        end
        checkOutput({tag, " busyWindow"}, 64'(errs), 64'd0);
        tick();
        checkOutput({tag, " busyFall"}, {63'b0, bus.busy}, 64'd0);
        checkOutput({tag, " donePulse"}, {63'b0, bus.done}, 64'd1);
        if (mfCheck) begin
            checkOutput({tag, " stallDrop"}, {63'b0, bus.stall}, 64'd0);
            checkOutput({tag, " mfNewLo"}, {32'b0, bus.hilo_rd}, {32'b0, exp[31:0]});
        end
        bus.mf_req = 1'b0;
        readHiLo(hi, lo);
        checkOutput({tag, " product"}, {hi, lo}, exp);
        tick();
        checkOutput({tag, " doneClear"}, {63'b0, bus.done}, 64'd0);
    endtask

    initial begin
        logic [31:0] hi, lo, ra, rb;
        logic [63:0] firstExp;
        logic        rs;
        int          errs;

        rst             = 1'b1;
        bus.mult_we     = 1'b0;
        bus.is_signed   = 1'b0;
        bus.src_a       = '0;
        bus.src_b       = '0;
        bus.mf_req      = 1'b0;
        bus.mf_hilo_sel = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        checkOutput("resetBusy", {63'b0, bus.busy}, 64'd0);
        checkOutput("resetDone", {63'b0, bus.done}, 64'd0);
        readHiLo(hi, lo);
        checkOutput("resetHiLo", {hi, lo}, 64'd0);

        // Small unsigned product
        runMult("mult7x6", 32'd7, 32'd6, 1'b0, 1'b0, hi, lo);
        checkOutput("mult7x6 const", {hi, lo}, 64'd42);

        // Idle MFHI/MFLO: no stall, current value same cycle
        bus.mf_req = 1'b1;
        bus.mf_hilo_sel = 1'b0;
        #1;
        checkOutput("idleMfStall", {63'b0, bus.stall}, 64'd0);
        checkOutput("idleMfLo", {32'b0, bus.hilo_rd}, 64'd42);
        bus.mf_req = 1'b0;
        tick();

        // Largest unsigned operands, with MFLO pending throughout
        runMult("multMax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, hi, lo);
        checkOutput("multMax const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        // Asynchronous reset in the middle of an operation
        applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        #1;
        checkOutput("midReset busy", {63'b0, bus.busy}, 64'd0);
        checkOutput("midReset done", {63'b0, bus.done}, 64'd0);
        readHiLo(hi, lo);
        checkOutput("midReset HiLo", {hi, lo}, 64'd0);
        rst = 1'b0;
        tick();
        checkOutput("postReset idle", {63'b0, bus.busy}, 64'd0);

        // mult_we held while busy: ignored, stalls, then restarts with 3*4
        ra = $urandom;
        rb = $urandom;
        firstExp = refProduct(ra, rb, 1'b0);
        bus.src_a = ra;
        bus.src_b = rb;
        bus.is_signed = 1'b0;
        bus.mult_we = 1'b1;
        tick();
        bus.src_a = 32'd3;
        bus.src_b = 32'd4;
        errs = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i > 0) tick();
            if (bus.busy !== 1'b1 || bus.stall !== 1'b1) errs++;
        end
        checkOutput("holdWe stallWindow", 64'(errs), 64'd0);
        tick();
        checkOutput("holdWe done", {63'b0, bus.done}, 64'd1);
        checkOutput("holdWe noStall", {63'b0, bus.stall}, 64'd0);
        readHiLo(hi, lo);
        checkOutput("holdWe first", {hi, lo}, firstExp);
        tick();
        bus.mult_we = 1'b0;
        checkOutput("holdWe restart", {63'b0, bus.busy}, 64'd1);
        for (int i = 0; i < WIDTH; i++) tick();
        checkOutput("holdWe done2", {63'b0, bus.done}, 64'd1);
        readHiLo(hi, lo);
        checkOutput("holdWe second", {hi, lo}, 64'd12);
        tick();

        // Signed request: result depends on whether signed mode is built in
        runMult("signedMix", 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0, hi, lo);
`ifdef MULT_SIGNED_EN
        checkOutput("signedMix const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
`else
        checkOutput("signedMix const", {hi, lo}, 64'h0000_0004_FFFF_FFF1);
`endif

        // Random operands against the arithmetic model
        for (int n = 0; n < 8; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            runMult($sformatf("rand%0d", n), ra, rb, rs, 1'(n % 2), hi, lo);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
